// File: rtl/ball_serve_sequencer.sv
// ball_serve_sequencer: Avalon-MM slave that sequences serve delay, ball enable and lives for the game.
// Software writes launch/pause/abort commands; ball-lost and game-over events raise a level interrupt.
module ball_serve_sequencer #(
    parameter int                 DELAY_W       = 24,
    parameter logic [DELAY_W-1:0] DEFAULT_DELAY = 5_000_000,
    parameter logic [3:0]         LIVES_INIT    = 4'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        ball_lost,
    output logic        ball_en,
    output logic        ball_reset,
    output logic        irq
);
    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, RUN = 3'd2, PAUSED = 3'd3, LOST = 3'd4, OVER = 3'd5;

    logic [2:0]         state;
    logic [DELAY_W-1:0] delay, cnt;
    logic [3:0]         lives;
    logic               pause, irq_en, lost_sticky, over_sticky;
    logic               wr, launch, abort;
    logic               unused_bits;

    assign wr          = chipselect & ~write_n;
    assign launch      = wr && address == 2'd0 && writedata[0];
    assign abort       = wr && address == 2'd0 && writedata[2];
    assign ball_en     = state == RUN;
    assign irq         = irq_en & (lost_sticky | over_sticky);
    assign unused_bits = ^writedata;

    always_comb begin
        readdata = address == 2'd0 ? {28'b0, irq_en, 1'b0, pause, 1'b0} :
                   address == 2'd1 ? {22'b0, over_sticky, lost_sticky, lives, 1'b0, state} :
                   address == 2'd2 ? 32'(delay) : {28'b0, lives};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            delay       <= DEFAULT_DELAY;
            lives       <= LIVES_INIT;
            pause       <= 1'b0;
            irq_en      <= 1'b0;
            lost_sticky <= 1'b0;
            over_sticky <= 1'b0;
            ball_reset  <= 1'b0;
        end else begin
            ball_reset <= 1'b0;
            if (wr && address == 2'd0) begin
                pause  <= writedata[1];
                irq_en <= writedata[3];
            end
            if (wr && address == 2'd1 && writedata[8]) lost_sticky <= 1'b0;
            if (wr && address == 2'd1 && writedata[9]) over_sticky <= 1'b0;
            if (wr && address == 2'd2) delay <= writedata[DELAY_W-1:0];
            if (wr && address == 2'd3 && (state == IDLE || state == OVER)) lives <= writedata[3:0];
            // Event sets come after the W1C clears so a coincident set wins
            if (abort) state <= IDLE;
            else case (state)
                IDLE, OVER: if (launch && lives != 4'd0) begin
                    state      <= SERVE;
                    cnt        <= delay;
                    ball_reset <= 1'b1;
                end
                SERVE: if (!pause) begin
                    if (cnt == '0) state <= RUN;
                    else cnt <= cnt - 1'b1;
                end
                RUN: if (ball_lost) begin
                    state       <= LOST;
                    lives       <= lives - 4'd1;
                    lost_sticky <= 1'b1;
                end else if (pause) state <= PAUSED;
                PAUSED: if (!pause) state <= RUN;
                LOST: if (lives == 4'd0) begin
                    state       <= OVER;
                    over_sticky <= 1'b1;
                end else begin
                    state      <= SERVE;
                    cnt        <= delay;
                    ball_reset <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_serve_sequencer.sv
// tb_ball_serve_sequencer: directed scenario bench for the serve sequencer with a short serve delay.
module tb_ball_serve_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        ball_lost = 1'b0;
    logic        ball_en, ball_reset, irq;
    int          errors = 0;
    int          checks = 0;

    ball_serve_sequencer #(.DELAY_W(24), .DEFAULT_DELAY(24'd10), .LIVES_INIT(4'd3)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .ball_lost(ball_lost), .ball_en(ball_en),
        .ball_reset(ball_reset), .irq(irq)
    );

    always #5 clk = ~clk;

    // Returns on the falling edge right after the write is captured
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1 d = readdata;
    endtask

    task automatic pulse_lost();
        @(negedge clk) ball_lost = 1'b1;
        @(negedge clk) ball_lost = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (!ball_en && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (ball_en !== 1'b1) begin errors++; $display("FAIL %s: ball_en never rose within %0d cycles", name, n); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        checks++; if ({ball_en, ball_reset, irq} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected 000", {ball_en, ball_reset, irq}); end
        reset = 1'b0;
        rd(2'd1, d); checks++; if (d !== 32'h30) begin errors++; $display("FAIL reset_status: got %h expected 00000030", d); end
        rd(2'd2, d); checks++; if (d !== 32'd10) begin errors++; $display("FAIL reset_delay: got %h expected 0000000a", d); end
        rd(2'd0, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    endtask

    task automatic test_launch();
        logic [31:0] d;
        int n = 0;
        wr(2'd0, 32'h1);
        checks++; if (ball_reset !== 1'b1) begin errors++; $display("FAIL launch_ball_reset: got %b expected 1", ball_reset); end
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd1) begin errors++; $display("FAIL launch_state: got %0d expected 1", d[2:0]); end
        @(negedge clk); n = 1;
        checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL ball_reset_width: got %b expected 0", ball_reset); end
        while (!ball_en && n < 30) begin @(negedge clk); n++; end
        checks++; if (n !== 11) begin errors++; $display("FAIL serve_latency: got %0d expected 11", n); end
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd2) begin errors++; $display("FAIL run_state: got %0d expected 2", d[2:0]); end
    endtask

    task automatic test_ball_lost_irq();
        logic [31:0] d;
        pulse_lost();
        rd(2'd1, d); checks++; if (d !== 32'h124) begin errors++; $display("FAIL lost_status: got %h expected 00000124", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b expected 0", irq); end
        @(negedge clk);
        rd(2'd1, d); checks++; if (d !== 32'h121) begin errors++; $display("FAIL reserve_status: got %h expected 00000121", d); end
        checks++; if (ball_reset !== 1'b1) begin errors++; $display("FAIL reserve_ball_reset: got %b expected 1", ball_reset); end
        wr(2'd0, 32'h8);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enabled: got %b expected 1", irq); end
        wr(2'd1, 32'h100);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b expected 0", irq); end
        wait_run("run_after_lost");
    endtask

    task automatic test_game_over();
        logic [31:0] d;
        wr(2'd0, 32'hC);
        wr(2'd3, 32'd3);
        wr(2'd0, 32'h9);
        wait_run("run_game");
        pulse_lost(); wait_run("run_life2");
        pulse_lost(); wait_run("run_life1");
        pulse_lost(); @(negedge clk);
        rd(2'd1, d); checks++; if (d !== 32'h305) begin errors++; $display("FAIL over_status: got %h expected 00000305", d); end
        checks++; if ({ball_en, irq} !== 2'b01) begin errors++; $display("FAIL over_outputs: got %b expected 01", {ball_en, irq}); end
        wr(2'd0, 32'h9); @(negedge clk);
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd5) begin errors++; $display("FAIL over_launch_ignored: got %0d expected 5", d[2:0]); end
        wr(2'd3, 32'd2);
        rd(2'd3, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL lives_write_over: got %h expected 00000002", d); end
        wr(2'd0, 32'h9);
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd1 || ball_reset !== 1'b1) begin errors++; $display("FAIL over_relaunch: got state %0d ball_reset %b expected 1 1", d[2:0], ball_reset); end
        wr(2'd1, 32'h300);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_both: got %b expected 0", irq); end
        wait_run("run_relaunch");
    endtask

    task automatic test_pause();
        logic [31:0] d;
        wr(2'd0, 32'hA);
        @(negedge clk);
        rd(2'd1, d); checks++; if (d !== 32'h23 || ball_en !== 1'b0) begin errors++; $display("FAIL pause_enter: got status %h ball_en %b expected 00000023 0", d, ball_en); end
        rd(2'd0, d); checks++; if (d !== 32'hA) begin errors++; $display("FAIL ctrl_read: got %h expected 0000000a", d); end
        pulse_lost();
        rd(2'd1, d); checks++; if (d !== 32'h23) begin errors++; $display("FAIL paused_lost_ignored: got %h expected 00000023", d); end
        wr(2'd0, 32'h8); @(negedge clk);
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd2 || ball_en !== 1'b1) begin errors++; $display("FAIL resume: got state %0d ball_en %b expected 2 1", d[2:0], ball_en); end
    endtask

    task automatic test_lost_beats_pause();
        logic [31:0] d;
        wr(2'd0, 32'hA);
        ball_lost = 1'b1;
        @(negedge clk) ball_lost = 1'b0;
        rd(2'd1, d); checks++; if (d[7:0] !== 8'h14) begin errors++; $display("FAIL lost_beats_pause: got %h expected 14", d[7:0]); end
        wr(2'd2, 32'd0);
        wr(2'd0, 32'hC);
        wr(2'd0, 32'h9);
        @(negedge clk);
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd2 || ball_en !== 1'b1) begin errors++; $display("FAIL zero_delay: got state %0d ball_en %b expected 2 1", d[2:0], ball_en); end
    endtask

    task automatic test_abort_and_reset();
        logic [31:0] d;
        wr(2'd2, 32'd20);
        wr(2'd0, 32'hC);
        @(negedge clk);
        address = 2'd0; writedata = 32'h9; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk) chipselect = 1'b0;
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd0) begin errors++; $display("FAIL write_n_high_ignored: got %0d expected 0", d[2:0]); end
        wr(2'd0, 32'h9);
        wr(2'd0, 32'hD);
        repeat (25) @(negedge clk);
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd0 || ball_en !== 1'b0) begin errors++; $display("FAIL abort_serve: got state %0d ball_en %b expected 0 0", d[2:0], ball_en); end
        wr(2'd0, 32'h9);
        wait_run("run_abort_test");
        wr(2'd3, 32'd7);
        rd(2'd3, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL lives_write_run: got %h expected 00000001", d); end
        wr(2'd0, 32'h9);
        rd(2'd1, d); checks++; if (d[2:0] !== 3'd2 || ball_reset !== 1'b0) begin errors++; $display("FAIL run_launch_ignored: got state %0d ball_reset %b expected 2 0", d[2:0], ball_reset); end
        #2 reset = 1'b1;
        #1 checks++; if (ball_en !== 1'b0) begin errors++; $display("FAIL async_ball_en: got %b expected 0", ball_en); end
        @(negedge clk) reset = 1'b0;
        wr(2'd2, 32'd20);
        wr(2'd0, 32'h9);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 rd(2'd1, d); checks++; if (d !== 32'h30) begin errors++; $display("FAIL reset_mid_serve_status: got %h expected 00000030", d); end
        rd(2'd2, d); checks++; if (d !== 32'd10) begin errors++; $display("FAIL reset_mid_serve_delay: got %h expected 0000000a", d); end
        checks++; if ({ball_en, ball_reset, irq} !== 3'b000) begin errors++; $display("FAIL reset_mid_serve_outputs: got %b expected 000", {ball_en, ball_reset, irq}); end
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_ball_lost_irq();
        test_game_over();
        test_pause();
        test_lost_beats_pause();
        test_abort_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
